mvm_result_drain: RTL

//  Downstream stage of the matrix-vector multiplier (mvm_*). Captures the K result words the
//  MVM streams out after its done pulse, tags the last word of each vector and buffers them in
//  a FIFO. Results leave through a valid/ready stream. can_start gates the upstream start.

---
 rtl/mvm_result_drain.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mvm_result_drain.sv
// -----------------------------------------------------------------------------
// mvm_result_drain
//
// Purpose:
//   This is the downstream stage of the matrix-vector multiplier. After the MVM
//   pulses mvm_done, it streams K result words on consecutive cycles. This block
//   captures those words and tags the last word of each vector. The words go into
//   a first-word-fall-through FIFO. Results leave through a valid/ready stream.
//   can_start tells upstream that a full vector can be absorbed, so it may start.
//
// Optional feature (compile-time macro):
//   MVM_DRAIN_RELU_EN - when defined, a word with its sign bit set is stored
//                       as 0. The last tag is not affected. When undefined,
//                       words are stored bit-exact.
//
// Ports:
//   clk        in   1                 clock, rising edge
//   reset      in   1                 synchronous, active-high reset
//   mvm_done   in   1                 1-cycle pulse; first result word valid this cycle
//   mvm_data   in   2*B               signed result word, words 0..K-1 on consecutive cycles
//   can_start  out  1                 IDLE and at least K free FIFO entries
//   busy       out  1                 capturing a vector
//   out_data   out  2*B               head-of-FIFO result word (0 when empty)
//   out_valid  out  1                 head entry valid
//   out_ready  in   1                 consumer accepts head entry
//   out_last   out  1                 head entry is word K-1 of its vector
//   level      out  $clog2(DEPTH+1)   FIFO occupancy
//   overflow   out  1                 sticky: a word was dropped on a full FIFO
//   proto_err  out  1                 sticky: mvm_done seen while capturing
// -----------------------------------------------------------------------------
module mvm_result_drain #(
    parameter int K     = 12,
    parameter int B     = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mvm_done,
    input  logic signed [2*B-1:0]      mvm_data,
    output logic                       can_start,
    output logic                       busy,
    output logic signed [2*B-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       proto_err
);

    localparam int DW = 2 * B;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < K) begin : g_depth_chk
            $error("mvm_result_drain: DEPTH (%0d) must be >= K (%0d)", DEPTH, K);
        end
    endgenerate

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_n;
    logic [DW:0]         r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [LW-1:0]       r_count;
    logic [LW-1:0]       w_count_n;
    logic                r_can_start;
    logic                w_can_start_n;
    logic                r_overflow;
    logic                r_proto_err;

    logic                w_push;
    logic                w_last;
    logic                w_proto;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_wr;
    logic                w_drop;
    logic [DW-1:0]       w_wdata;
    logic [DW:0]         w_head;

    // Pointers wrap explicitly, so any DEPTH works and not just powers of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Capture FSM: word 0 is pushed in the same cycle as mvm_done.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_push    = 1'b0;
        w_last    = 1'b0;
        w_proto   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mvm_done) begin
                    w_push = 1'b1;
                    if (K == 1) begin
                        w_last = 1'b1;
                    end else begin
                        w_state_n = S_CAPTURE;
                        w_cnt_n   = CW'(1);
                    end
                end
            end
            S_CAPTURE: begin
                w_push  = 1'b1;
                // A second done while capturing is only flagged. The vector in flight keeps its framing.
                w_proto = mvm_done;
                if (r_cnt == CW'(K - 1)) begin
                    w_last    = 1'b1;
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef MVM_DRAIN_RELU_EN
        w_wdata = mvm_data[DW-1] ? '0 : mvm_data;
`else
        w_wdata = mvm_data;
`endif
    end

    // A push on a full FIFO still succeeds when a pop frees the head in the same cycle.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == LW'(DEPTH));
        w_pop   = !w_empty && out_ready;
        w_wr    = w_push && (!w_full || w_pop);
        w_drop  = w_push && w_full && !w_pop;
        case ({w_wr, w_pop})
            2'b10:   w_count_n = r_count + LW'(1);
            2'b01:   w_count_n = r_count - LW'(1);
            default: w_count_n = r_count;
        endcase
        // can_start looks ahead one cycle, so the registered output matches the state that follows.
        w_can_start_n = (w_state_n == S_IDLE) && ((DEPTH - int'(w_count_n)) >= K);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_can_start <= 1'b1;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_count     <= w_count_n;
            r_can_start <= w_can_start_n;
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_proto) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Storage is not reset; r_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_last, w_wdata};
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : w_head[DW-1:0];
    assign out_last  = !w_empty && w_head[DW];
    assign busy      = (r_state == S_CAPTURE);
    assign level     = r_count;
    assign can_start = r_can_start;
    assign overflow  = r_overflow;
    assign proto_err = r_proto_err;

endmodule
